// File: rtl/router_pkg.sv
// Router-wide constants shared by the port datapath blocks.
package router_pkg;

  localparam int unsigned NUM_IN = 5;
  localparam int unsigned FLIT_W = 64;
  localparam int unsigned VC_BIT = FLIT_W - 1;

  typedef enum int unsigned {
    PORT_N   = 0,
    PORT_S   = 1,
    PORT_W   = 2,
    PORT_E   = 3,
    PORT_NIC = 4
  } port_e;

endpackage

// File: rtl/rr_arbiter.sv
// N-way round-robin arbiter: scans from the pointer, one-hot grant, pointer
// moves past the granted index only when the grant is consumed (advance).
module rr_arbiter #(
  parameter int unsigned N = 5
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [N-1:0] req,
  input  logic         advance,
  output logic [N-1:0] grant
);

  localparam int unsigned PW = (N > 1) ? $clog2(N) : 1;

  logic [PW-1:0] ptr;
  logic [PW-1:0] grant_idx;
  logic          found;
  int unsigned   idx;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    idx       = 0;
    for (int unsigned k = 0; k < N; k++) begin
      idx = (32'(ptr) + k) % N;
      if (!found && req[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        grant_idx  = PW'(idx);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr <= '0;
    end else if (advance && found) begin
      ptr <= (grant_idx == PW'(N - 1)) ? '0 : grant_idx + 1'b1;
    end
  end

endmodule

// File: rtl/output_port_arbiter.sv
// Output port with two one-flit VC slots: inputs fill slot[polarity] through a
// round-robin grant while slot[~polarity] is presented downstream.
module output_port_arbiter #(
  parameter int unsigned NUM_IN = router_pkg::NUM_IN,
  parameter int unsigned FLIT_W = router_pkg::FLIT_W
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     polarity,
  input  logic [NUM_IN-1:0]        in_req,
  input  logic [NUM_IN-1:0]        in_so,
  input  logic [NUM_IN*FLIT_W-1:0] in_do,
  output logic [NUM_IN-1:0]        in_ro,
  output logic                     out_so,
  input  logic                     out_ro,
  output logic [FLIT_W-1:0]        out_do
);

  logic [1:0]        slot_full;
  logic [FLIT_W-1:0] slot_data [2];

  logic [NUM_IN-1:0] eligible;
  logic [NUM_IN-1:0] grant;
  logic [FLIT_W-1:0] acc_data;
  logic              accept;
  logic              drain;

  always_comb begin
    eligible = '0;
    acc_data = '0;
    for (int unsigned i = 0; i < NUM_IN; i++) begin
      eligible[i] = in_req[i] & (in_do[i*FLIT_W + FLIT_W - 1] == polarity) & ~slot_full[polarity];
      if (grant[i]) acc_data = acc_data | in_do[i*FLIT_W +: FLIT_W];
    end
  end

  rr_arbiter #(.N(NUM_IN)) u_rr (
    .clk     (clk),
    .reset   (reset),
    .req     (eligible),
    .advance (accept),
    .grant   (grant)
  );

  // Grant is masked during reset since the slot state alone would make it eligible.
  assign in_ro  = reset ? '0 : grant;
  assign accept = |(in_ro & in_so);
  assign out_so = slot_full[~polarity];
  assign out_do = slot_full[~polarity] ? slot_data[~polarity] : '0;
  assign drain  = out_so & out_ro;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      slot_full    <= '0;
      slot_data[0] <= '0;
      slot_data[1] <= '0;
    end else begin
      if (accept) begin
        slot_full[polarity] <= 1'b1;
        slot_data[polarity] <= acc_data;
      end
      if (drain) slot_full[~polarity] <= 1'b0;
    end
  end

endmodule

// File: tb/tb_output_port_arbiter.sv
// Scoreboard bench for output_port_arbiter: a queue-based slot model and a
// round-robin reference predict grants and drained flits.
module tb_output_port_arbiter;

  logic         clk = 1'b0;
  logic         reset;
  logic         polarity;
  logic [4:0]   in_req;
  logic [4:0]   in_so;
  logic [319:0] in_do;
  logic [4:0]   in_ro;
  logic         out_so;
  logic         out_ro;
  logic [63:0]  out_do;

  always #5 clk = ~clk;

  output_port_arbiter #(.NUM_IN(5), .FLIT_W(64)) dut (
    .clk      (clk),
    .reset    (reset),
    .polarity (polarity),
    .in_req   (in_req),
    .in_so    (in_so),
    .in_do    (in_do),
    .in_ro    (in_ro),
    .out_so   (out_so),
    .out_ro   (out_ro),
    .out_do   (out_do)
  );

  int          n_vec = 0;
  int          n_err = 0;
  bit          run = 1'b0;
  int          rr_next = 0;
  logic [63:0] q0[$];
  logic [63:0] q1[$];
  int          acc_log[$];
  logic [63:0] mon_exp;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int slot_size(input logic p);
    return p ? q1.size() : q0.size();
  endfunction

  // Downstream monitor: every cycle the slot opposite polarity is what must be shown.
  always @(negedge clk) begin
    if (!reset && run) begin
      check("out_so", 64'(out_so), 64'(slot_size(!polarity) != 0));
      if (out_so && out_ro && slot_size(!polarity) != 0) begin
        if (polarity) mon_exp = q0.pop_front();
        else          mon_exp = q1.pop_front();
        check("out_do", out_do, mon_exp);
      end else if (!out_so) begin
        check("out_do_idle", out_do, 64'd0);
      end
    end
  end

  task automatic cycle(input logic pol, input logic [4:0] req, input logic [4:0] vcs,
                       input logic [4:0] so, input bit so_eq, input logic oro,
                       input bit fix_en, input logic [63:0] fix, output logic [4:0] got_ro);
    logic [63:0] d [5];
    int          g;
    logic [4:0]  exp_ro;
    polarity = pol;
    in_req   = req;
    out_ro   = oro;
    for (int i = 0; i < 5; i++) begin
      d[i] = fix_en ? fix : {$urandom(), $urandom()};
      d[i][63] = vcs[i];
      in_do[i*64 +: 64] = d[i];
    end
    g = -1;
    for (int k = 0; k < 5; k++) begin
      int idx;
      idx = (rr_next + k) % 5;
      if (g < 0 && req[idx] && vcs[idx] == pol && slot_size(pol) == 0) g = idx;
    end
    exp_ro = (g >= 0) ? 5'(1 << g) : 5'd0;
    in_so  = so_eq ? exp_ro : so;
    @(negedge clk);
    got_ro = in_ro;
    check("in_ro", 64'(in_ro), 64'(exp_ro));
    if (g >= 0 && in_so[g]) begin
      if (pol) q1.push_back(d[g]);
      else     q0.push_back(d[g]);
      rr_next = (g + 1) % 5;
      acc_log.push_back(g);
    end
    @(posedge clk);
    #1;
  endtask

  logic [4:0] got;
  int         exp034 [4] = '{0, 2, 4, 0};

  initial begin
    reset    = 1'b1;
    polarity = 1'b0;
    in_req   = '1;
    in_so    = '1;
    in_do    = '0;
    out_ro   = 1'b1;
    @(posedge clk);
    #1;
    check("rst_in_ro", 64'(in_ro), 64'd0);
    check("rst_out_so", 64'(out_so), 64'd0);
    check("rst_out_do", out_do, 64'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    run   = 1'b1;

    // Inputs 0, 2, 4 request VC0 every cycle; grants land on polarity-0 cycles.
    acc_log.delete();
    for (int n = 0; n < 4; n++) begin
      cycle(1'b0, 5'b10101, 5'b00000, 5'b0, 1'b1, 1'b1, 1'b0, 64'd0, got);
      cycle(1'b1, 5'b10101, 5'b00000, 5'b0, 1'b1, 1'b1, 1'b0, 64'd0, got);
    end
    check("rr_count", 64'(acc_log.size()), 64'd4);
    for (int n = 0; n < 4 && n < acc_log.size(); n++)
      check("rr_order", 64'(acc_log[n]), 64'(exp034[n]));

    // Single requester, known flit, presented the next cycle.
    cycle(1'b0, 5'b00010, 5'b00000, 5'b0, 1'b1, 1'b1, 1'b1, 64'h0000_0000_DEAD_BEEF, got);
    check("beef_grant", 64'(got), 64'h2);
    cycle(1'b1, 5'b00000, 5'b00000, 5'b0, 1'b0, 1'b1, 1'b0, 64'd0, got);

    // VC mismatch on input 3 does not block input 4.
    cycle(1'b1, 5'b11000, 5'b10000, 5'b0, 1'b1, 1'b1, 1'b0, 64'd0, got);
    check("vc_skip", 64'(got), 64'h10);
    cycle(1'b0, 5'b00000, 5'b00000, 5'b0, 1'b0, 1'b1, 1'b0, 64'd0, got);

    // Back-pressure: fill both slots, hold, then drain.
    cycle(1'b0, 5'b00001, 5'b00000, 5'b0, 1'b1, 1'b0, 1'b0, 64'd0, got);
    cycle(1'b1, 5'b00010, 5'b11111, 5'b0, 1'b1, 1'b0, 1'b0, 64'd0, got);
    for (int n = 0; n < 4; n++) begin
      cycle(1'(n), 5'b11111, (n % 2 == 1) ? 5'b11111 : 5'b00000, 5'b11111, 1'b0, 1'b0, 1'b0, 64'd0, got);
      check("full_no_grant", 64'(got), 64'd0);
    end
    cycle(1'b0, 5'b00000, 5'b00000, 5'b0, 1'b0, 1'b1, 1'b0, 64'd0, got);
    cycle(1'b1, 5'b00000, 5'b00000, 5'b0, 1'b0, 1'b1, 1'b0, 64'd0, got);
    check("bp_empty", 64'(q0.size() + q1.size()), 64'd0);

    // Same-cycle accept into slot0 and drain of slot1.
    cycle(1'b1, 5'b00010, 5'b00010, 5'b0, 1'b1, 1'b0, 1'b0, 64'd0, got);
    cycle(1'b0, 5'b00100, 5'b00000, 5'b0, 1'b1, 1'b1, 1'b0, 64'd0, got);
    check("acc_drain_grant", 64'(got), 64'h4);
    cycle(1'b1, 5'b00000, 5'b00000, 5'b0, 1'b0, 1'b0, 1'b0, 64'd0, got);
    cycle(1'b0, 5'b00000, 5'b00000, 5'b0, 1'b0, 1'b0, 1'b0, 64'd0, got);
    cycle(1'b1, 5'b00000, 5'b00000, 5'b0, 1'b0, 1'b1, 1'b0, 64'd0, got);

    // Randomized traffic.
    for (int n = 0; n < 400; n++)
      cycle(1'($urandom()), 5'($urandom()), 5'($urandom()), 5'($urandom()),
            1'($urandom() % 2), 1'($urandom() % 4 != 0), 1'b0, 64'd0, got);

    // Reset with both slots full and a handshake in flight.
    cycle(1'b1, 5'b00000, 5'b00000, 5'b0, 1'b0, 1'b1, 1'b0, 64'd0, got);
    cycle(1'b0, 5'b00000, 5'b00000, 5'b0, 1'b0, 1'b1, 1'b0, 64'd0, got);
    cycle(1'b0, 5'b11111, 5'b00000, 5'b0, 1'b1, 1'b0, 1'b0, 64'd0, got);
    cycle(1'b1, 5'b11111, 5'b11111, 5'b0, 1'b1, 1'b0, 1'b0, 64'd0, got);
    polarity = 1'b0;
    in_req   = '1;
    in_so    = '1;
    out_ro   = 1'b1;
    for (int i = 0; i < 5; i++) in_do[i*64 +: 64] = {1'b0, 63'(i + 1)};
    #2;
    reset = 1'b1;
    q0.delete();
    q1.delete();
    rr_next = 0;
    #1;
    check("midrst_in_ro", 64'(in_ro), 64'd0);
    check("midrst_out_so", 64'(out_so), 64'd0);
    check("midrst_out_do", out_do, 64'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    cycle(1'b0, 5'b11111, 5'b00000, 5'b0, 1'b0, 1'b1, 1'b0, 64'd0, got);
    check("post_rst_ptr", 64'(got), 64'h1);

    cycle(1'b0, 5'b00000, 5'b00000, 5'b0, 1'b0, 1'b1, 1'b0, 64'd0, got);
    cycle(1'b1, 5'b00000, 5'b00000, 5'b0, 1'b0, 1'b1, 1'b0, 64'd0, got);
    cycle(1'b0, 5'b00000, 5'b00000, 5'b0, 1'b0, 1'b1, 1'b0, 64'd0, got);
    check("final_empty", 64'(q0.size() + q1.size()), 64'd0);
    run = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/output_port_arbiter.md
OUTPUT_PORT_ARBITER -- requirements
Module: output_port_arbiter

Interface
REQ-001 Parameter NUM_IN, default 5, number of input controllers sharing this output port (index 0 N, 1 S, 2 W, 3 E, 4 NIC).
REQ-002 Parameter FLIT_W, default 64, flit width; bit FLIT_W-1 is the VC bit.
REQ-003 clk  input  1  single system clock; all state on its rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 polarity  input  1  router VC phase; internal transfers use VC == polarity, external transfers use VC != polarity.
REQ-006 in_req  input  NUM_IN  input i holds a valid flit routed to this port; must not depend on in_ro.
REQ-007 in_so  input  NUM_IN  input i commits its flit this cycle.
REQ-008 in_do  input  NUM_IN*FLIT_W  flit from input i, slice [i*FLIT_W +: FLIT_W].
REQ-009 in_ro  output  NUM_IN  one-hot or zero grant; ready to input i.
REQ-010 out_so  output  1  output flit valid toward downstream router/NIC.
REQ-011 out_ro  input  1  downstream ready.
REQ-012 out_do  output  FLIT_W  output flit.

Function
REQ-013 Two one-flit VC slots, slot0 and slot1, each holding a full bit and a FLIT_W data register.
REQ-014 Eligible requester: in_req[i]=1, in_do[i] VC bit == polarity, and slot[polarity] empty.
REQ-015 in_ro is combinational from registered state, in_req, in_do and polarity; at most one bit is high.
REQ-016 Grant goes to the first eligible index scanning rr_ptr, rr_ptr+1, ..., wrapping 4->0.
REQ-017 Accept = in_ro[g] & in_so[g]; on accept, slot[polarity] loads in_do[g] unmodified, is marked full next edge, and rr_ptr <= (g==NUM_IN-1) ? 0 : g+1.
REQ-018 With no accept, rr_ptr holds, even if a grant was issued; in_so without in_ro is ignored.
REQ-019 out_so = slot[~polarity].full; out_do = slot[~polarity].data, or all-zero when that slot is empty.
REQ-020 Drain = out_so & out_ro; slot[~polarity] clears on that edge.
REQ-021 Accept into slot[p] and drain from slot[~p] in the same cycle are both performed; the slots never conflict.
REQ-022 Both slots full: in_ro = 0; out_so is asserted from the slot opposite polarity.
REQ-023 Latency: a flit accepted in cycle t (polarity p) is first presented on out_do in the next cycle where polarity = ~p, normally t+1.
REQ-024 A requester whose VC bit mismatches polarity receives no grant that cycle and does not block lower-priority eligible requesters.
REQ-025 Throughput: one accept and one drain per cycle maximum.

Reset
REQ-026 On reset assertion, asynchronously: both full bits 0, both data registers 0, rr_ptr 0.
REQ-027 Outputs during reset: in_ro 0, out_so 0, out_do 0.
REQ-028 A flit mid-handshake when reset asserts is discarded; there is no partial state.
REQ-029 First accept is possible on the first rising edge after reset deasserts.

Structure
REQ-030 Shared package router_pkg holds: FLIT_W, VC_BIT, NUM_IN, port index constants (PORT_N=0, PORT_S=1, PORT_W=2, PORT_E=3, PORT_NIC=4).
REQ-031 Sub-module rr_arbiter (NUM_IN-way round-robin: request vector in; one-hot grant out; pointer register updated on an advance strobe) is instantiated once.
REQ-032 Slot storage and the output mux live in output_port_arbiter.

Verification
REQ-033 Reset mid-run with both slots full -> out_so=0, in_ro=0 immediately; rr_ptr=0 after release.
REQ-034 polarity=0; inputs 0, 2, 4 request VC0 every cycle with in_so=in_ro; out_ro=1 -> grants in order 0,2,4,0 on successive polarity-0 cycles.
REQ-035 polarity=0; input 1 presents flit 0x0000_0000_DEAD_BEEF (VC0) -> in_ro=00010; next cycle (polarity=1) out_so=1, out_do=0x0000_0000_DEAD_BEEF.
REQ-036 out_ro=0 with both slots filled -> in_ro=0 for all requests; flits hold; after out_ro=1 they drain in polarity order with no loss.
REQ-037 polarity=1; input 3 requests with VC0 and input 4 requests with VC1 -> in_ro=10000; input 3 is not granted.
REQ-038 Simultaneous accept (polarity=0, input 2) and drain of slot1 in one cycle -> both complete; slot0 full and slot1 empty afterward.
